// File: rtl/sec_pkg.sv
// Shared definitions for the counter readout/clear sequencer:
// default geometry and the FSM state encoding.
package sec_pkg;

  localparam int NUM_CNT_DEF = 3;
  localparam int DIR_W_DEF   = 2;
  localparam int DATA_W_DEF  = 32;
  localparam int PESO_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    BORRAR    = 3'd1,
    ASENTAR   = 3'd2,
    MUESTREAR = 3'd3,
    ENTREGAR  = 3'd4,
    FIN       = 3'd5
  } estado_t;

endpackage

// File: rtl/escalador_energia.sv
// Registered unsigned count x weight multiplier, one cycle of latency.
// The product is kept at full width so it can never overflow.
module escalador_energia #(
  parameter int DATA_W = 32,
  parameter int PESO_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [DATA_W-1:0]        cuenta,
  input  logic [PESO_W-1:0]        peso,
  output logic [DATA_W+PESO_W-1:0] energia
);

  localparam int PROD_W = DATA_W + PESO_W;

  // Capture the product only when enabled so the result stays put afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      energia <= '0;
    end else if (en) begin
      energia <= PROD_W'(cuenta) * PROD_W'(peso);
    end
  end

endmodule

// File: rtl/secuenciador_contadores.sv
// Readout/clear sequencer for the transition-counter memory.
// Clears every counter or reads each one, scales it by a latched energy
// weight and streams one result per counter.
// Optional build macro MIN_ENERGIA_EN adds min_idx/min_energia tracking.
//
// Result handshake: res_valid rises in ENTREGAR and stays high, with
// res_idx/res_cuenta/res_energia frozen, until the cycle in which
// res_ready is also high; that rising edge is the transfer.
module secuenciador_contadores
  import sec_pkg::*;
#(
  parameter int NUM_CNT = NUM_CNT_DEF,
  parameter int DIR_W   = DIR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PESO_W  = PESO_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inicio_borrar,
  input  logic                     inicio_leer,
  input  logic [PESO_W-1:0]        peso,
  output logic [DIR_W-1:0]         dir,
  output logic                     LE,
  input  logic [DATA_W-1:0]        dato_in,
  output logic [DATA_W-1:0]        dato_out,
  output logic                     dato_oe,
  output logic [DIR_W-1:0]         res_idx,
  output logic [DATA_W-1:0]        res_cuenta,
  output logic [DATA_W+PESO_W-1:0] res_energia,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     ocupado,
  output logic                     listo,
`ifdef MIN_ENERGIA_EN
  output logic [DIR_W-1:0]         min_idx,
  output logic [DATA_W+PESO_W-1:0] min_energia,
`endif
  output estado_t                  estado
);

  localparam logic [DIR_W-1:0] ULTIMO = DIR_W'(NUM_CNT - 1);

  estado_t            estado_q, estado_d;
  logic [DIR_W-1:0]   idx;
  logic [PESO_W-1:0]  peso_q;
  logic               arranque_borrar, arranque_leer, entrega, ultimo;

  // Clear has priority; a simultaneous read request is simply dropped.
  assign arranque_borrar = (estado_q == IDLE) && inicio_borrar;
  assign arranque_leer   = (estado_q == IDLE) && !inicio_borrar && inicio_leer;
  assign entrega         = (estado_q == ENTREGAR) && res_ready;
  assign ultimo          = (idx == ULTIMO);

  assign dir      = idx;
  assign dato_out = '0;
  assign estado   = estado_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) estado_q <= IDLE;
    else       estado_q <= estado_d;
  end

  // Next state and Moore outputs; LE stays high (safe) outside BORRAR.
  always_comb begin
    estado_d  = estado_q;
    LE        = 1'b1;
    dato_oe   = 1'b0;
    res_valid = 1'b0;
    listo     = 1'b0;
    ocupado   = 1'b1;
    case (estado_q)
      IDLE: begin
        ocupado = 1'b0;
        if (inicio_borrar)    estado_d = BORRAR;
        else if (inicio_leer) estado_d = ASENTAR;
      end
      BORRAR: begin
        LE      = 1'b0;
        dato_oe = 1'b1;
        if (ultimo) estado_d = FIN;
      end
      ASENTAR:   estado_d = MUESTREAR;
      MUESTREAR: estado_d = ENTREGAR;
      ENTREGAR: begin
        res_valid = 1'b1;
        if (res_ready) estado_d = ultimo ? FIN : ASENTAR;
      end
      FIN: begin
        listo    = 1'b1;
        estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

  // Counter index: restarts at each operation, never wraps past the last entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (arranque_borrar || arranque_leer) begin
      idx <= '0;
    end else if ((estado_q == BORRAR) && !ultimo) begin
      idx <= idx + 1'b1;
    end else if (entrega && !ultimo) begin
      idx <= idx + 1'b1;
    end else if (estado_q == FIN) begin
      idx <= '0;
    end
  end

  // Weight is frozen for the whole read so later changes on peso are ignored.
  always_ff @(posedge clk) begin
    if (reset)              peso_q <= '0;
    else if (arranque_leer) peso_q <= peso;
  end

  // Raw count and index captured alongside the scaled energy.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_cuenta <= '0;
      res_idx    <= '0;
    end else if (estado_q == MUESTREAR) begin
      res_cuenta <= dato_in;
      res_idx    <= idx;
    end
  end

  escalador_energia #(
    .DATA_W (DATA_W),
    .PESO_W (PESO_W)
  ) u_escalador (
    .clk     (clk),
    .reset   (reset),
    .en      (estado_q == MUESTREAR),
    .cuenta  (dato_in),
    .peso    (peso_q),
    .energia (res_energia)
  );

`ifdef MIN_ENERGIA_EN
  // Running minimum: first entry loads, later ones only if strictly smaller.
  always_ff @(posedge clk) begin
    if (reset) begin
      min_idx     <= '0;
      min_energia <= '0;
    end else if (entrega && ((res_idx == '0) || (res_energia < min_energia))) begin
      min_idx     <= res_idx;
      min_energia <= res_energia;
    end
  end
`endif

endmodule

// File: tb/tb_secuenciador_contadores.sv
// Self-checking bench for secuenciador_contadores: counter memory model,
// transaction-level expected queue, per-cycle compare process.
module tb_secuenciador_contadores;

  localparam int NCNT  = 3;
  localparam int DW    = 2;
  localparam int DATAW = 32;
  localparam int PW    = 16;
  localparam int EW    = DATAW + PW;
  localparam int EXP_W = DW + DATAW + EW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             inicio_borrar, inicio_leer, res_ready;
  logic [PW-1:0]    peso;
  logic [DW-1:0]    dir, res_idx;
  logic             LE, dato_oe, res_valid, ocupado, listo;
  logic [DATAW-1:0] dato_in, dato_out, res_cuenta;
  logic [EW-1:0]    res_energia;
  logic [2:0]       estado;
`ifdef MIN_ENERGIA_EN
  logic [DW-1:0]    min_idx;
  logic [EW-1:0]    min_energia;
`endif

  secuenciador_contadores dut (
    .clk(clk), .reset(reset), .inicio_borrar(inicio_borrar), .inicio_leer(inicio_leer),
    .peso(peso), .dir(dir), .LE(LE), .dato_in(dato_in), .dato_out(dato_out),
    .dato_oe(dato_oe), .res_idx(res_idx), .res_cuenta(res_cuenta),
    .res_energia(res_energia), .res_valid(res_valid), .res_ready(res_ready),
    .ocupado(ocupado), .listo(listo),
`ifdef MIN_ENERGIA_EN
    .min_idx(min_idx), .min_energia(min_energia),
`endif
    .estado(estado)
  );

  // ---------------- counter memory (environment) ----------------
  logic [DATAW-1:0] mem [4];
  logic [DATAW-1:0] load_v [4];
  logic             load_en;
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 4; i++) mem[i] <= load_v[i];
    end else if (!LE) begin
      mem[dir] <= dato_oe ? dato_out : 32'hDEAD_BEEF;
    end
  end
  assign dato_in = mem[dir];

  // Abstract memory contents as the model believes them to be.
  logic [DATAW-1:0] mm [NCNT];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] e_mon;
  logic [DW-1:0]    dir_trace[$];
  logic [EW-1:0]    got_e[$];
  int le0_count = 0, listo_count = 0, last_listo_cyc = 0;
  int first_valid_cyc = -1, hs_count = 0, last_hs_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("oe_with_le0", dato_oe, !LE);
      chk("dato_out_zero", dato_out, 0);
      chk("dir_range", dir <= DW'(NCNT - 1), 1);
      if (!LE) begin
        le0_count++;
        dir_trace.push_back(dir);
      end
      if (listo) begin
        listo_count++;
        last_listo_cyc = cyc;
      end
      if (res_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e_mon = exp_q[0];
          chk("res_idx", res_idx, e_mon[EXP_W-1 -: DW]);
          chk("res_cuenta", res_cuenta, e_mon[EW +: DATAW]);
          chk("res_energia", res_energia, e_mon[EW-1:0]);
          chk("dir_hold", dir, e_mon[EXP_W-1 -: DW]);
          if (res_ready) begin
            void'(exp_q.pop_front());
            hs_count++;
            last_hs_cyc = cyc;
            got_e.push_back(res_energia);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic load_mem(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    load_v[0] = a; load_v[1] = b; load_v[2] = c; load_v[3] = 32'd0;
    mm[0] = a; mm[1] = b; mm[2] = c;
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_clear(input bit with_read);
    int s, l0, t;
    le0_count = 0;
    dir_trace.delete();
    l0 = listo_count;
    inicio_borrar = 1'b1;
    inicio_leer   = with_read;
    s = cyc;
    tick();
    inicio_borrar = 1'b0;
    inicio_leer   = 1'b0;
    chk("ocupado_clear", ocupado, 1);
    t = 0;
    while (listo_count == l0 && t < 50) begin
      tick();
      t++;
    end
    chk("clear_listo_count", listo_count - l0, 1);
    chk("clear_le0_cycles", le0_count, NCNT);
    for (int i = 0; i < NCNT; i++) begin
      if (i < dir_trace.size()) chk("clear_dir_seq", dir_trace[i], i);
    end
    chk("clear_listo_time", last_listo_cyc - s, NCNT + 1);
    for (int i = 0; i < NCNT; i++) begin
      mm[i] = '0;
      chk("clear_mem", mem[i], mm[i]);
    end
    chk("ocupado_after_clear", ocupado, 0);
  endtask

  // mode: 0 ready high, 1 random ready, 2 stall idx 1 for 5 cycles,
  //       3 reset during ENTREGAR of idx 1, 4 extra start pulse mid-read
  task automatic do_read(input logic [PW-1:0] p, input int mode);
    int s, l0, hs0, t, stall;
    logic [EW-1:0] e;
`ifdef MIN_ENERGIA_EN
    logic [DW-1:0] mi;
    logic [EW-1:0] me;
    mi = '0;
    me = 48'(mm[0]) * 48'(p);
`endif
    for (int i = 0; i < NCNT; i++) begin
      e = 48'(mm[i]) * 48'(p);
      exp_q.push_back({DW'(i), mm[i], e});
`ifdef MIN_ENERGIA_EN
      if (e < me) begin
        mi = DW'(i);
        me = e;
      end
`endif
    end
    hs0 = hs_count;
    l0 = listo_count;
    first_valid_cyc = -1;
    got_e.delete();
    peso = p;
    res_ready = 1'b1;
    inicio_leer = 1'b1;
    s = cyc;
    tick();
    inicio_leer = 1'b0;
    chk("ocupado_read", ocupado, 1);
    stall = 5;
    t = 0;
    while (listo_count == l0 && t < 300) begin
      peso = PW'($urandom);
      res_ready = 1'b1;
      if (mode == 1) res_ready = ($urandom_range(0, 2) != 0);
      if (mode == 2 && (hs_count - hs0) == 1 && res_valid && stall > 0) begin
        res_ready = 1'b0;
        stall--;
      end
      inicio_leer = (mode == 4 && t == 4);
      if (mode == 3 && (hs_count - hs0) == 1 && res_valid) begin
        res_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        res_ready = 1'b1;
        exp_q.delete();
        chk("abort_ocupado", ocupado, 0);
        chk("abort_le", LE, 1);
        chk("abort_valid", res_valid, 0);
        chk("abort_listo", listo, 0);
        chk("abort_results", hs_count - hs0, 1);
        idle(5);
        chk("abort_no_listo", listo_count, l0);
        return;
      end
      tick();
      t++;
    end
    inicio_leer = 1'b0;
    res_ready = 1'b1;
    if (listo_count == l0) $display("read did not complete, state=%0d", estado);
    chk("read_listo_count", listo_count - l0, 1);
    chk("results_count", hs_count - hs0, NCNT);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("first_valid_latency", first_valid_cyc - s, 3);
    chk("listo_after_last_hs", last_listo_cyc - last_hs_cyc, 1);
    chk("ocupado_after_read", ocupado, 0);
`ifdef MIN_ENERGIA_EN
    chk("min_idx", min_idx, mi);
    chk("min_energia", min_energia, me);
`endif
  endtask

  task automatic pin_energies(input string name, input logic [47:0] a, input logic [47:0] b,
                              input logic [47:0] c);
    chk({name, "_n"}, got_e.size(), 3);
    if (got_e.size() == 3) begin
      chk({name, "_e0"}, got_e[0], a);
      chk({name, "_e1"}, got_e[1], b);
      chk({name, "_e2"}, got_e[2], c);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    inicio_borrar = 1'b0;
    inicio_leer = 1'b0;
    peso = '0;
    res_ready = 1'b1;
    load_en = 1'b0;
    for (int i = 0; i < 4; i++) load_v[i] = '0;
    load_mem(0, 0, 0);
    idle(2);
    chk("rst_dir", dir, 0);
    chk("rst_le", LE, 1);
    chk("rst_oe", dato_oe, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_listo", listo, 0);
    chk("rst_res", {res_idx, res_cuenta, res_energia}, 0);
    reset = 1'b0;
    idle(2);

    // Clear sweep
    load_mem(7, 9, 11);
    do_clear(1'b0);
    idle(3);

    // Read with ready held high
    load_mem(100, 250, 40);
    do_read(16'd3, 0);
    pin_energies("read_const", 300, 750, 120);
    idle(2);

    // Backpressure on idx 1
    do_read(16'd3, 2);
    pin_energies("read_stall", 300, 750, 120);
    idle(2);

    // Both starts together: clear only
    load_mem(7, 9, 11);
    do_clear(1'b1);
    idle(6);

    // Start pulse during a read is ignored
    load_mem(100, 250, 40);
    do_read(16'd3, 4);
    idle(8);

    // Reset mid-read, then a full read
    do_read(16'd3, 3);
    do_read(16'd3, 0);
    pin_energies("read_after_abort", 300, 750, 120);
    idle(2);

    // Tie on the minimum
    load_mem(500, 40, 40);
    do_read(16'd2, 0);
    pin_energies("read_tie", 1000, 80, 80);
`ifdef MIN_ENERGIA_EN
    chk("tie_min_idx", min_idx, 1);
    chk("tie_min_energia", min_energia, 80);
    do_clear(1'b0);
    chk("min_kept_idx", min_idx, 1);
    chk("min_kept_energia", min_energia, 80);
`endif
    idle(2);

    // Randomized operations
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        load_mem($urandom, $urandom, $urandom);
      end else begin
        load_mem($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20));
      end
      if ($urandom_range(0, 3) == 0) do_clear(1'b0);
      do_read(PW'($urandom_range(0, 65535)), 1);
      idle($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
